// File: rtl/vfirst_pkg.sv
// Shared types and constants for the vfirst_scan mask-path unit.
// Build option: VFIRST_MASK_EN (see vfirst_scan.sv).
package vfirst_pkg;

    typedef enum logic [1:0] {
        FIRST = 2'd0,
        SBF   = 2'd1,
        SIF   = 2'd2,
        SOF   = 2'd3
    } mode_e;

    localparam int MAX_RESP_WIDTH = 256;

    // Sliced down to the response width by the user.
    localparam logic [MAX_RESP_WIDTH-1:0] NO_FOUND = '1;

    function automatic int NUM_CHUNKS(input int req_width, input int chunk_width);
        return req_width / chunk_width;
    endfunction

endpackage

// File: rtl/vfirst_scan_if.sv
// Beat-in / result-out bundle of vfirst_scan; the master drives beats, the slave is the scan unit.
// With VFIRST_MASK_EN defined the bundle also carries in_vm, in_v0 and out_be.
interface vfirst_scan_if #(
    parameter int REQ_DATA_WIDTH  = 64,
    parameter int RESP_DATA_WIDTH = 64,
    parameter int IDX_BITS        = 10
);
    logic                       in_valid;
    logic                       in_start;
    logic                       in_last;
    vfirst_pkg::mode_e          in_mode;
    logic [REQ_DATA_WIDTH-1:0]  in_m0;
    logic [IDX_BITS-1:0]        in_idx;
`ifdef VFIRST_MASK_EN
    logic                       in_vm;
    logic [REQ_DATA_WIDTH-1:0]  in_v0;
    logic [REQ_DATA_WIDTH-1:0]  out_be;
`endif
    logic                       out_valid;
    logic                       out_last;
    logic [RESP_DATA_WIDTH-1:0] out_vec;
    logic                       out_found;

`ifdef VFIRST_MASK_EN
    modport master (
        output in_valid, in_start, in_last, in_mode, in_m0, in_idx, in_vm, in_v0,
        input  out_valid, out_last, out_vec, out_found, out_be
    );
    modport slave (
        input  in_valid, in_start, in_last, in_mode, in_m0, in_idx, in_vm, in_v0,
        output out_valid, out_last, out_vec, out_found, out_be
    );
`else
    modport master (
        output in_valid, in_start, in_last, in_mode, in_m0, in_idx,
        input  out_valid, out_last, out_vec, out_found
    );
    modport slave (
        input  in_valid, in_start, in_last, in_mode, in_m0, in_idx,
        output out_valid, out_last, out_vec, out_found
    );
`endif

endinterface

// File: rtl/vfirst_chunk_enc.sv
// Combinational priority encoder: reports whether any bit is set and the index of the lowest one.
module vfirst_chunk_enc #(
    parameter int CHUNK_WIDTH = 16
) (
    input  logic [CHUNK_WIDTH-1:0]         bits,
    output logic                           hit,
    output logic [$clog2(CHUNK_WIDTH)-1:0] idx
);
    localparam int LW = $clog2(CHUNK_WIDTH);

    // Walk downwards so the lowest set bit is the last one written.
    always_comb begin
        hit = |bits;
        idx = '0;
        for (int i = CHUNK_WIDTH - 1; i >= 0; i--) begin
            if (bits[i]) idx = LW'(i);
        end
    end

endmodule

// File: rtl/vfirst_scan.sv
// Multi-beat first-set-bit scanner (vfirst.m / vmsbf / vmsif / vmsof), two-stage pipeline.
// Build option: VFIRST_MASK_EN adds the in_vm/in_v0 element mask and the out_be byte-enable view.
module vfirst_scan
    import vfirst_pkg::*;
#(
    parameter int REQ_DATA_WIDTH  = 64,
    parameter int RESP_DATA_WIDTH = 64,
    parameter int IDX_BITS        = 10,
    parameter int CHUNK_WIDTH     = 16
) (
    input logic        clk,
    input logic        rst,
    vfirst_scan_if.slave bus
);
    localparam int NC = NUM_CHUNKS(REQ_DATA_WIDTH, CHUNK_WIDTH);
    localparam int LW = $clog2(CHUNK_WIDTH);
    localparam int FW = $clog2(REQ_DATA_WIDTH);
    localparam logic [REQ_DATA_WIDTH-1:0] ONE = REQ_DATA_WIDTH'(1);

    logic [REQ_DATA_WIDTH-1:0]  active;
    logic [REQ_DATA_WIDTH-1:0]  scan;
    logic [NC-1:0]              enc_hit;
    logic [NC-1:0][LW-1:0]      enc_idx;

    logic                       s0_valid;
    logic                       s0_start;
    logic                       s0_last;
    mode_e                      s0_mode;
    logic [IDX_BITS-1:0]        s0_idx;
    logic [NC-1:0]              s0_hit;
    logic [NC-1:0][LW-1:0]      s0_lidx;
    logic [REQ_DATA_WIDTH-1:0]  s0_active;

    logic                       found_q, found_d;
    logic [IDX_BITS-1:0]        idx_q, idx_d;

    logic                       prior, hit, found;
    logic [FW-1:0]              first;
    logic [REQ_DATA_WIDTH-1:0]  onehot, below, mask;
    logic [IDX_BITS-1:0]        result_idx;

    logic                       nxt_valid, nxt_last, nxt_found;
    logic [RESP_DATA_WIDTH-1:0] nxt_vec;
    logic [REQ_DATA_WIDTH-1:0]  nxt_be;

`ifdef VFIRST_MASK_EN
    assign active = bus.in_vm ? '1 : bus.in_v0;
`else
    assign active = '1;
`endif
    assign scan = bus.in_m0 & active;

    for (genvar c = 0; c < NC; c++) begin : g_enc
        vfirst_chunk_enc #(.CHUNK_WIDTH(CHUNK_WIDTH)) u_enc (
            .bits (scan[c*CHUNK_WIDTH +: CHUNK_WIDTH]),
            .hit  (enc_hit[c]),
            .idx  (enc_idx[c])
        );
    end

    // Stage 0: per-chunk encoder results plus the beat's side fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_valid <= 1'b0;
            s0_start <= 1'b0;
            s0_last  <= 1'b0;
            s0_mode  <= FIRST;
            s0_idx   <= '0;
            s0_hit   <= '0;
            s0_lidx  <= '0;
        end else begin
            s0_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s0_start <= bus.in_start;
                s0_last  <= bus.in_last;
                s0_mode  <= bus.in_mode;
                s0_idx   <= bus.in_idx;
                s0_hit   <= enc_hit;
                s0_lidx  <= enc_idx;
            end
        end
    end

`ifdef VFIRST_MASK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)               s0_active <= '0;
        else if (bus.in_valid) s0_active <= active;
    end
`else
    assign s0_active = '1;
`endif

    // Stage 1: merge chunks, apply the sticky "already found" state and form the result.
    always_comb begin
        prior = s0_start ? 1'b0 : found_q;
        hit   = |s0_hit;
        found = prior | hit;
        first = '0;
        for (int c = NC - 1; c >= 0; c--) begin
            if (s0_hit[c]) first = FW'(c * CHUNK_WIDTH) + FW'(s0_lidx[c]);
        end
        onehot     = ONE << first;
        below      = onehot - ONE;
        result_idx = prior ? idx_q : s0_idx + IDX_BITS'(first);

        mask = '0;
        if (!prior) begin
            unique case (s0_mode)
                SBF:     mask = hit ? below : '1;
                SIF:     mask = hit ? (below | onehot) : '1;
                SOF:     mask = hit ? onehot : '0;
                default: mask = '0;
            endcase
        end

        nxt_valid = 1'b0;
        nxt_last  = 1'b0;
        nxt_found = 1'b0;
        nxt_vec   = '0;
        nxt_be    = '0;
        found_d   = found_q;
        idx_d     = idx_q;

        if (s0_valid) begin
            found_d = s0_last ? 1'b0 : found;
            if (!prior && hit) idx_d = result_idx;
            if (s0_mode == FIRST) begin
                if (s0_last) begin
                    nxt_valid = 1'b1;
                    nxt_last  = 1'b1;
                    nxt_found = found;
                    nxt_vec   = found ? RESP_DATA_WIDTH'(result_idx)
                                      : NO_FOUND[RESP_DATA_WIDTH-1:0];
                    nxt_be    = s0_active;
                end
            end else begin
                nxt_valid = 1'b1;
                nxt_last  = s0_last;
                nxt_found = found;
                nxt_vec   = RESP_DATA_WIDTH'(mask & s0_active);
                nxt_be    = s0_active;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            found_q       <= 1'b0;
            idx_q         <= '0;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.out_found <= 1'b0;
            bus.out_vec   <= '0;
        end else begin
            found_q       <= found_d;
            idx_q         <= idx_d;
            bus.out_valid <= nxt_valid;
            bus.out_last  <= nxt_last;
            bus.out_found <= nxt_found;
            bus.out_vec   <= nxt_vec;
        end
    end

`ifdef VFIRST_MASK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) bus.out_be <= '0;
        else     bus.out_be <= nxt_be;
    end
`else
    logic unused_be;
    assign unused_be = ^nxt_be;
`endif

endmodule

// File: tb/tb_vfirst_scan.sv
// Directed self-checking bench for vfirst_scan; results appear two clock edges after a beat is driven.
// Build option: VFIRST_MASK_EN also runs the masked-element scenario.
module tb_vfirst_scan;
    import vfirst_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    vfirst_scan_if #(.REQ_DATA_WIDTH(64), .RESP_DATA_WIDTH(64), .IDX_BITS(10)) bus ();

    vfirst_scan #(
        .REQ_DATA_WIDTH(64), .RESP_DATA_WIDTH(64), .IDX_BITS(10), .CHUNK_WIDTH(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Inputs change on the falling edge; outputs are read there as well.
    task automatic step(input logic v, input logic st, input logic la, input mode_e md,
                        input logic [63:0] m0, input logic [9:0] ix);
        @(negedge clk);
        bus.in_valid = v;
        bus.in_start = st;
        bus.in_last  = la;
        bus.in_mode  = md;
        bus.in_m0    = m0;
        bus.in_idx   = ix;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, FIRST, 64'h0, 10'd0);
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.in_start = 1'b0; bus.in_last = 1'b0;
        bus.in_mode = FIRST; bus.in_m0 = '0; bus.in_idx = '0;
`ifdef VFIRST_MASK_EN
        bus.in_vm = 1'b1; bus.in_v0 = '1;
`endif
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_valid got %0b want 0", bus.out_valid); end
        n_cmp++; if (bus.out_vec !== 64'h0) begin n_bad++; $display("[TB] FAIL reset_vec got %h want 0", bus.out_vec); end
        n_cmp++; if (bus.out_found !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_found got %0b want 0", bus.out_found); end
        n_cmp++; if (bus.out_last !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_last got %0b want 0", bus.out_last); end
        rst = 1'b0;
    endtask

    task automatic test_first_single();
        step(1'b1, 1'b1, 1'b1, FIRST, 64'h0000_0000_0000_0100, 10'd0);
        idle();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL first1_early_valid got %0b want 0", bus.out_valid); end
        idle();
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL first1_valid got %0b want 1", bus.out_valid); end
        n_cmp++; if (bus.out_vec !== 64'd8) begin n_bad++; $display("[TB] FAIL first1_vec got %0d want 8", bus.out_vec); end
        n_cmp++; if (bus.out_found !== 1'b1) begin n_bad++; $display("[TB] FAIL first1_found got %0b want 1", bus.out_found); end
        n_cmp++; if (bus.out_last !== 1'b1) begin n_bad++; $display("[TB] FAIL first1_last got %0b want 1", bus.out_last); end
        idle();
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.out_vec !== 64'h0) begin n_bad++; $display("[TB] FAIL first1_idle got v=%0b vec=%h want v=0 vec=0", bus.out_valid, bus.out_vec); end
    endtask

    task automatic test_first_multi();
        step(1'b1, 1'b1, 1'b0, FIRST, 64'h0, 10'd0);
        step(1'b1, 1'b0, 1'b0, FIRST, 64'h0, 10'd64);
        step(1'b1, 1'b0, 1'b1, FIRST, 64'h20, 10'd128);
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL firstN_beat0_silent got %0b want 0", bus.out_valid); end
        idle();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL firstN_beat1_silent got %0b want 0", bus.out_valid); end
        idle();
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL firstN_valid got %0b want 1", bus.out_valid); end
        n_cmp++; if (bus.out_vec !== 64'd133) begin n_bad++; $display("[TB] FAIL firstN_vec got %0d want 133", bus.out_vec); end
        n_cmp++; if (bus.out_found !== 1'b1) begin n_bad++; $display("[TB] FAIL firstN_found got %0b want 1", bus.out_found); end
    endtask

    task automatic test_first_none();
        step(1'b1, 1'b1, 1'b0, FIRST, 64'h0, 10'd0);
        step(1'b1, 1'b0, 1'b1, FIRST, 64'h0, 10'd64);
        idle();
        idle();
        n_cmp++; if (bus.out_vec !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_bad++; $display("[TB] FAIL none_vec got %h want all-ones", bus.out_vec); end
        n_cmp++; if (bus.out_found !== 1'b0) begin n_bad++; $display("[TB] FAIL none_found got %0b want 0", bus.out_found); end
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL none_valid got %0b want 1", bus.out_valid); end
    endtask

    // Earlier hit must win over a later one; a hit past the top of the index space wraps.
    task automatic test_first_sticky_wrap();
        step(1'b1, 1'b1, 1'b0, FIRST, 64'h8, 10'd0);
        step(1'b1, 1'b0, 1'b1, FIRST, 64'h2, 10'd64);
        idle();
        idle();
        n_cmp++; if (bus.out_vec !== 64'd3) begin n_bad++; $display("[TB] FAIL sticky_vec got %0d want 3", bus.out_vec); end
        step(1'b1, 1'b1, 1'b1, FIRST, 64'h0000_0000_4000_0000, 10'd1000);
        idle();
        idle();
        n_cmp++; if (bus.out_vec !== 64'd6) begin n_bad++; $display("[TB] FAIL wrap_vec got %0d want 6", bus.out_vec); end
    endtask

    task automatic test_sif_sbf();
        step(1'b1, 1'b1, 1'b0, SIF, 64'h10, 10'd0);
        step(1'b1, 1'b0, 1'b1, SIF, 64'h1, 10'd64);
        step(1'b1, 1'b1, 1'b0, SBF, 64'h10, 10'd0);
        n_cmp++; if (bus.out_vec !== 64'h1F || bus.out_found !== 1'b1) begin n_bad++; $display("[TB] FAIL sif_b0 got vec=%h f=%0b want 1f/1", bus.out_vec, bus.out_found); end
        step(1'b1, 1'b0, 1'b1, SBF, 64'h1, 10'd64);
        n_cmp++; if (bus.out_vec !== 64'h0 || bus.out_found !== 1'b1 || bus.out_last !== 1'b1) begin n_bad++; $display("[TB] FAIL sif_b1 got vec=%h f=%0b l=%0b want 0/1/1", bus.out_vec, bus.out_found, bus.out_last); end
        step(1'b1, 1'b1, 1'b1, SIF, 64'h0, 10'd0);
        n_cmp++; if (bus.out_vec !== 64'h0F || bus.out_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL sbf_b0 got vec=%h v=%0b want 0f/1", bus.out_vec, bus.out_valid); end
        idle();
        n_cmp++; if (bus.out_vec !== 64'h0 || bus.out_last !== 1'b1) begin n_bad++; $display("[TB] FAIL sbf_b1 got vec=%h l=%0b want 0/1", bus.out_vec, bus.out_last); end
        idle();
        n_cmp++; if (bus.out_vec !== 64'hFFFF_FFFF_FFFF_FFFF || bus.out_found !== 1'b0) begin n_bad++; $display("[TB] FAIL sif_none got vec=%h f=%0b want all-ones/0", bus.out_vec, bus.out_found); end
    endtask

    task automatic test_back_to_back();
        step(1'b1, 1'b1, 1'b0, SOF, 64'h0001_0000_0000_8000, 10'd0);
        step(1'b1, 1'b0, 1'b1, SOF, 64'h0000_0000_0000_00FF, 10'd64);
        step(1'b1, 1'b1, 1'b1, SOF, 64'h0000_0100_0000_0000, 10'd0);
        n_cmp++; if (bus.out_vec !== 64'h8000 || bus.out_found !== 1'b1) begin n_bad++; $display("[TB] FAIL sof_a0 got vec=%h f=%0b want 8000/1", bus.out_vec, bus.out_found); end
        step(1'b1, 1'b1, 1'b0, SOF, 64'h0, 10'd0);
        n_cmp++; if (bus.out_vec !== 64'h0 || bus.out_found !== 1'b1 || bus.out_last !== 1'b1) begin n_bad++; $display("[TB] FAIL sof_a1 got vec=%h f=%0b l=%0b want 0/1/1", bus.out_vec, bus.out_found, bus.out_last); end
        step(1'b1, 1'b0, 1'b1, SOF, 64'h8000_0000_0000_0000, 10'd64);
        n_cmp++; if (bus.out_vec !== 64'h0000_0100_0000_0000 || bus.out_last !== 1'b1) begin n_bad++; $display("[TB] FAIL sof_b0 got vec=%h l=%0b want 10000000000/1", bus.out_vec, bus.out_last); end
        idle();
        n_cmp++; if (bus.out_vec !== 64'h0 || bus.out_found !== 1'b0 || bus.out_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL sof_c0 got vec=%h f=%0b v=%0b want 0/0/1", bus.out_vec, bus.out_found, bus.out_valid); end
        idle();
        n_cmp++; if (bus.out_vec !== 64'h8000_0000_0000_0000 || bus.out_found !== 1'b1) begin n_bad++; $display("[TB] FAIL sof_c1 got vec=%h f=%0b want 8000000000000000/1", bus.out_vec, bus.out_found); end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 1'b1, 1'b0, SOF, 64'h1, 10'd0);
        step(1'b1, 1'b0, 1'b0, SOF, 64'h0, 10'd64);
        idle();
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_vec !== 64'h1) begin n_bad++; $display("[TB] FAIL pre_reset got v=%0b vec=%h want 1/1", bus.out_valid, bus.out_vec); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.out_vec !== 64'h0 || bus.out_found !== 1'b0) begin n_bad++; $display("[TB] FAIL async_reset got v=%0b vec=%h f=%0b want 0/0/0", bus.out_valid, bus.out_vec, bus.out_found); end
        @(negedge clk);
        rst = 1'b0;
        idle();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL post_reset_valid got %0b want 0", bus.out_valid); end
        step(1'b1, 1'b1, 1'b1, SOF, 64'h2, 10'd0);
        idle();
        idle();
        n_cmp++; if (bus.out_vec !== 64'h2 || bus.out_found !== 1'b1 || bus.out_last !== 1'b1) begin n_bad++; $display("[TB] FAIL fresh_vec got vec=%h f=%0b l=%0b want 2/1/1", bus.out_vec, bus.out_found, bus.out_last); end
    endtask

`ifdef VFIRST_MASK_EN
    task automatic test_masked();
        step(1'b1, 1'b1, 1'b1, FIRST, 64'h3, 10'd0);
        bus.in_vm = 1'b0; bus.in_v0 = 64'h2;
        step(1'b1, 1'b1, 1'b1, SIF, 64'h0, 10'd0);
        bus.in_vm = 1'b0; bus.in_v0 = 64'hF0;
        step(1'b1, 1'b1, 1'b0, FIRST, 64'h0, 10'd0);
        bus.in_valid = 1'b0; bus.in_vm = 1'b1; bus.in_v0 = '1;
        n_cmp++; if (bus.out_vec !== 64'd1 || bus.out_found !== 1'b1) begin n_bad++; $display("[TB] FAIL masked_first got vec=%0d f=%0b want 1/1", bus.out_vec, bus.out_found); end
        n_cmp++; if (bus.out_be !== 64'h2) begin n_bad++; $display("[TB] FAIL masked_be got %h want 2", bus.out_be); end
        idle();
        n_cmp++; if (bus.out_vec !== 64'hF0 || bus.out_found !== 1'b0) begin n_bad++; $display("[TB] FAIL masked_sif got vec=%h f=%0b want f0/0", bus.out_vec, bus.out_found); end
        idle();
    endtask
`endif

    initial begin
        #100000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_first_single();
        test_first_multi();
        test_first_none();
        test_first_sticky_wrap();
        test_sif_sbf();
        test_back_to_back();
        test_reset_mid();
`ifdef VFIRST_MASK_EN
        test_masked();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
